// File: rtl/fm_rx_pkg.sv
// Shared receive-path definitions: default widths, demodulator state encoding
// and the saturating narrowing helper used by the audio back ends.
package fm_rx_pkg;

    localparam int DEFAULT_PHASE_W = 40;
    localparam int DEFAULT_AUDIO_W = 16;
    localparam int SAT_W           = 64;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } demod_state_t;

    // Clamp a wide signed value into the signed range of an out_w-bit word.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] x,
        input int unsigned             out_w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)
            return hi;
        else if (x < lo)
            return lo;
        else
            return x;
    endfunction

endpackage

// File: rtl/fm_decim_acc.sv
// Block-averaging decimator: sums DECIM signed frequency errors, scales the
// block sum by an arithmetic shift and emits one saturated audio sample.
module fm_decim_acc
    import fm_rx_pkg::*;
#(
    parameter int PHASE_W = DEFAULT_PHASE_W,
    parameter int AUDIO_W = DEFAULT_AUDIO_W,
    parameter int DECIM   = 8,
    parameter int SHIFT   = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic signed [PHASE_W-1:0]  i_err,
    output logic signed [AUDIO_W-1:0]  o_audio,
    output logic                       o_valid
);

    localparam int LOG2  = $clog2(DECIM);
    localparam int ACC_W = PHASE_W + LOG2;

    logic signed [ACC_W-1:0]   r_acc;
    logic        [LOG2-1:0]    r_cnt;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [ACC_W-1:0]   w_shifted;
    logic signed [SAT_W-1:0]   w_sat;
    logic                      w_last;

    // The final error of a block is folded in combinationally so the output
    // lands one edge after the DECIM-th sample rather than two.
    assign w_sum     = r_acc + $signed({{LOG2{i_err[PHASE_W-1]}}, i_err});
    assign w_shifted = w_sum >>> (SHIFT + LOG2);
    assign w_sat     = saturate($signed({{(SAT_W-ACC_W){w_shifted[ACC_W-1]}}, w_shifted}),
                                AUDIO_W);
    assign w_last    = (r_cnt == LOG2'(DECIM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            o_audio <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid) begin
                if (w_last) begin
                    o_audio <= w_sat[AUDIO_W-1:0];
                    o_valid <= 1'b1;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_acc   <= w_sum;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fm_phase_demod.sv
// FM phase demodulator: differences successive phase words, removes the
// carrier increment and hands the frequency error to the block decimator.
module fm_phase_demod
    import fm_rx_pkg::*;
#(
    parameter int PHASE_W = DEFAULT_PHASE_W,
    parameter int AUDIO_W = DEFAULT_AUDIO_W,
    parameter int DECIM   = 8,
    parameter int SHIFT   = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic        [PHASE_W-1:0]  i_phase_in,
    input  logic                       i_phase_valid,
    input  logic        [PHASE_W-1:0]  i_carrier_pincr,
    output logic signed [AUDIO_W-1:0]  o_audio_out,
    output logic                       o_audio_valid
);

    demod_state_t              r_state;
    logic        [PHASE_W-1:0] r_prev_phase;
    logic        [PHASE_W-1:0] w_diff;
    logic signed [PHASE_W-1:0] w_err;
    logic                      w_err_valid;

    // Modulo-2^PHASE_W subtraction makes phase wrap-around transparent.
    assign w_diff      = i_phase_in - r_prev_phase;
    assign w_err       = $signed(w_diff - i_carrier_pincr);
    assign w_err_valid = i_phase_valid && (r_state == RUN);

    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values, so ordering inside the block cannot matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= PRIME;
            r_prev_phase <= '0;
        end else if (i_phase_valid) begin
            r_prev_phase <= i_phase_in;
            case (r_state)
                PRIME:   r_state <= RUN;
                RUN:     r_state <= RUN;
                default: r_state <= PRIME;
            endcase
        end
    end

    fm_decim_acc #(
        .PHASE_W (PHASE_W),
        .AUDIO_W (AUDIO_W),
        .DECIM   (DECIM),
        .SHIFT   (SHIFT)
    ) u_decim_acc (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_err_valid),
        .i_err   (w_err),
        .o_audio (o_audio_out),
        .o_valid (o_audio_valid)
    );

endmodule

// File: tb/tb_fm_phase_demod.sv
// Self-checking bench for fm_phase_demod (DECIM=4, SHIFT=20): an arithmetic
// reference model is compared every cycle, plus literal per-scenario results.
module tb_fm_phase_demod;

    localparam int PHASE_W = 40;
    localparam int AUDIO_W = 16;
    localparam int DECIM   = 4;
    localparam int SHIFT   = 20;
    localparam int TOT_SH  = 22;

    localparam longint MOD  = longint'(1) << PHASE_W;
    localparam longint HALF = longint'(1) << (PHASE_W - 1);
    localparam longint CAR  = longint'(1) << 32;
    localparam longint DEV  = longint'(1) << 24;
    localparam longint BIG  = longint'(1) << 38;

    logic                       clk = 1'b0;
    logic                       rst = 1'b0;
    logic        [PHASE_W-1:0]  phase_in = '0;
    logic                       phase_valid = 1'b0;
    logic        [PHASE_W-1:0]  carrier_pincr = '0;
    logic signed [AUDIO_W-1:0]  audio_out;
    logic                       audio_valid;

    fm_phase_demod #(
        .PHASE_W (PHASE_W),
        .AUDIO_W (AUDIO_W),
        .DECIM   (DECIM),
        .SHIFT   (SHIFT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_phase_in      (phase_in),
        .i_phase_valid   (phase_valid),
        .i_carrier_pincr (carrier_pincr),
        .o_audio_out     (audio_out),
        .o_audio_valid   (audio_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: demodulation expressed as plain integer arithmetic.
    bit     m_primed = 0;
    longint m_prev = 0;
    longint m_sum = 0;
    int     m_n = 0;
    int     m_accepted = 0;
    bit     exp_valid = 0;
    longint exp_audio = 0;

    function automatic longint wrap_signed(input longint v);
        longint r;
        r = v % MOD;
        if (r < 0) r += MOD;
        if (r >= HALF) r -= MOD;
        return r;
    endfunction

    function automatic longint floor_scale_sat(input longint s);
        longint d, q, hi;
        d  = longint'(1) << TOT_SH;
        q  = s / d;
        if ((s % d != 0) && (s < 0)) q--;
        hi = (longint'(1) << (AUDIO_W - 1)) - 1;
        if (q > hi) q = hi;
        if (q < -hi - 1) q = -hi - 1;
        return q;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_primed = 0; m_prev = 0; m_sum = 0; m_n = 0; m_accepted = 0;
            exp_valid = 0; exp_audio = 0;
        end else begin
            exp_valid = 0;
            if (phase_valid) begin
                m_accepted++;
                if (m_primed) begin
                    m_sum += wrap_signed(longint'(phase_in) - m_prev - longint'(carrier_pincr));
                    m_n++;
                    if (m_n == DECIM) begin
                        exp_audio = floor_scale_sat(m_sum);
                        exp_valid = 1;
                        m_sum = 0;
                        m_n = 0;
                    end
                end
                m_prev   = longint'(phase_in);
                m_primed = 1;
            end
        end
    end

    // Per-cycle comparison and pulse capture, away from the active edge.
    bit     compare_en = 0;
    int     pulse_cnt = 0;
    int     first_at = -1;
    longint last_audio = 0;

    always @(negedge clk) begin
        if (compare_en) begin
            check("audio_valid", longint'(audio_valid), longint'(exp_valid));
            check("audio_out", longint'(audio_out), exp_audio);
            if (audio_valid === 1'b1) begin
                if (pulse_cnt == 0) first_at = m_accepted;
                pulse_cnt++;
                last_audio = longint'(audio_out);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        phase_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulse_cnt = 0;
        first_at = -1;
    endtask

    task automatic run_stream(input longint start, input longint step, input longint car,
                              input int n, input int gap);
        logic [PHASE_W-1:0] p;
        p = PHASE_W'(start);
        for (int k = 0; k < n; k++) begin
            phase_in      = p;
            carrier_pincr = PHASE_W'(car);
            phase_valid   = 1'b1;
            @(negedge clk);
            phase_valid   = 1'b0;
            repeat (gap) @(negedge clk);
            p = p + PHASE_W'(step);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic scenario(input string name, input longint start, input longint step,
                            input int gap, input longint want);
        do_reset();
        run_stream(start, step, CAR, 2 * DECIM + 1, gap);
        check({name, "_pulses"}, pulse_cnt, 2);
        check({name, "_first_at"}, first_at, DECIM + 1);
        check({name, "_value"}, last_audio, want);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_audio_out", longint'(audio_out), 0);
        check("reset_audio_valid", longint'(audio_valid), 0);
        rst = 1'b0;
        compare_en = 1;

        // Model self-pins against hand-computed values.
        check("model_wrap", wrap_signed(MOD - 1), -1);
        check("model_floor", floor_scale_sat(-1), -1);
        check("model_sat", floor_scale_sat(longint'(1) << 40), 32767);

        scenario("carrier_only", 0, CAR, 0, 0);
        scenario("pos_dev", 0, CAR + DEV, 0, 16);
        scenario("neg_dev", 0, CAR - DEV, 0, -16);
        scenario("wrap", MOD - (longint'(1) << 30), CAR + DEV, 0, 16);
        scenario("sat_pos", 0, CAR + BIG, 0, 32767);
        scenario("sat_neg", 0, CAR - BIG, 0, -32768);
        scenario("gapped", 12345, CAR + DEV, 2, 16);

        // Reset mid-block with a large partial sum; rst also collides with a valid.
        do_reset();
        run_stream(0, CAR + BIG, CAR, 3, 0);
        phase_in    = 40'h55_0000_0000;
        phase_valid = 1'b1;
        rst         = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        phase_valid = 1'b0;
        check("midreset_audio_out", longint'(audio_out), 0);
        check("midreset_audio_valid", longint'(audio_valid), 0);
        pulse_cnt = 0;
        first_at  = -1;
        run_stream(0, CAR - DEV, CAR, DECIM + 1, 0);
        check("midreset_pulses", pulse_cnt, 1);
        check("midreset_first_at", first_at, DECIM + 1);
        check("midreset_value", last_audio, -16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
